// File: rtl/read_stage.sv
// read_stage: register-read pipeline stage; forwards from execute/writeback,
// inserts a load-use bubble and latches resolved operands for execute.
module read_stage #(
  parameter int A_SIZE = 10,
  parameter int D_SIZE = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_id_valid,
  input  logic [6:0]        i_id_opcode,
  input  logic [2:0]        i_id_dest,
  input  logic [2:0]        i_id_src1,
  input  logic [2:0]        i_id_src2,
  input  logic              i_id_use1,
  input  logic              i_id_use2,
  input  logic              i_flush,
  input  logic              i_ex_hold,
  input  logic              i_ex_valid,
  input  logic              i_ex_is_load,
  input  logic [2:0]        i_ex_dest,
  input  logic [D_SIZE-1:0] i_ex_result,
  input  logic              i_wb_write_en,
  input  logic [2:0]        i_wb_dest,
  input  logic [D_SIZE-1:0] i_wb_result,
  input  logic [D_SIZE-1:0] i_data_1_reg,
  input  logic [D_SIZE-1:0] i_data_2_reg,
  output logic [2:0]        o_addr_1_reg,
  output logic [2:0]        o_addr_2_reg,
  output logic              o_stall_up,
  output logic              o_rd_valid,
  output logic [6:0]        o_rd_opcode,
  output logic [2:0]        o_rd_dest,
  output logic [D_SIZE-1:0] o_rd_op1,
  output logic [D_SIZE-1:0] o_rd_op2
);
  // A_SIZE only sizes the downstream memory-address path; reject nonsense here.
  if (A_SIZE < 1 || D_SIZE < 1) begin : g_bad_param
    $error("read_stage: A_SIZE and D_SIZE must be positive");
  end
  logic              w_ex_fwd;
  logic              w_fwd1_ex;
  logic              w_fwd2_ex;
  logic              w_fwd1_wb;
  logic              w_fwd2_wb;
  logic              w_luh;
  logic [D_SIZE-1:0] w_op1;
  logic [D_SIZE-1:0] w_op2;
  logic              r_valid;
  logic [6:0]        r_opcode;
  logic [2:0]        r_dest;
  logic [D_SIZE-1:0] r_op1;
  logic [D_SIZE-1:0] r_op2;
  assign o_addr_1_reg = i_id_src1;
  assign o_addr_2_reg = i_id_src2;
  // A load's data is not ready in execute, so only ALU results forward from there.
  assign w_ex_fwd  = i_ex_valid && !i_ex_is_load;
  assign w_fwd1_ex = w_ex_fwd && (i_ex_dest == i_id_src1);
  assign w_fwd2_ex = w_ex_fwd && (i_ex_dest == i_id_src2);
  assign w_fwd1_wb = i_wb_write_en && (i_wb_dest == i_id_src1);
  assign w_fwd2_wb = i_wb_write_en && (i_wb_dest == i_id_src2);
  assign w_op1 = w_fwd1_ex ? i_ex_result : w_fwd1_wb ? i_wb_result : i_data_1_reg;
  assign w_op2 = w_fwd2_ex ? i_ex_result : w_fwd2_wb ? i_wb_result : i_data_2_reg;
  assign w_luh = i_id_valid && i_ex_valid && i_ex_is_load &&
                 ((i_id_use1 && (i_ex_dest == i_id_src1)) ||
                  (i_id_use2 && (i_ex_dest == i_id_src2)));
  assign o_stall_up = i_ex_hold || (w_luh && !i_flush);
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid  <= 1'b0;
      r_opcode <= '0;
      r_dest   <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
    end else if (i_flush || (!i_ex_hold && w_luh)) begin
      r_valid <= 1'b0;
    end else if (!i_ex_hold) begin
      r_valid  <= i_id_valid;
      r_opcode <= i_id_opcode;
      r_dest   <= i_id_dest;
      r_op1    <= w_op1;
      r_op2    <= w_op2;
    end
  end
  assign o_rd_valid  = r_valid;
  assign o_rd_opcode = r_opcode;
  assign o_rd_dest   = r_dest;
  assign o_rd_op1    = r_op1;
  assign o_rd_op2    = r_op2;
endmodule

// File: tb/tb_read_stage.sv
// tb_read_stage: directed vectors for read_stage; expectations are queued at
// issue time and a negedge monitor compares them against the pipeline register.
module tb_read_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_use1, id_use2, flush, ex_hold, ex_valid, ex_is_load, wb_write_en;
  logic [6:0]  id_opcode;
  logic [2:0]  id_dest, id_src1, id_src2, ex_dest, wb_dest;
  logic [31:0] ex_result, wb_result, data_1, data_2;
  logic [2:0]  addr_1, addr_2;
  logic        stall_up, rd_valid;
  logic [6:0]  rd_opcode;
  logic [2:0]  rd_dest;
  logic [31:0] rd_op1, rd_op2;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  typedef struct {
    int          due;
    string       nm;
    logic        v;
    logic [6:0]  opc;
    logic [2:0]  dst;
    logic [31:0] op1;
    logic [31:0] op2;
    bit          full;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  read_stage #(.A_SIZE(10), .D_SIZE(32)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_id_valid(id_valid), .i_id_opcode(id_opcode), .i_id_dest(id_dest),
    .i_id_src1(id_src1), .i_id_src2(id_src2), .i_id_use1(id_use1), .i_id_use2(id_use2),
    .i_flush(flush), .i_ex_hold(ex_hold), .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load),
    .i_ex_dest(ex_dest), .i_ex_result(ex_result),
    .i_wb_write_en(wb_write_en), .i_wb_dest(wb_dest), .i_wb_result(wb_result),
    .i_data_1_reg(data_1), .i_data_2_reg(data_2),
    .o_addr_1_reg(addr_1), .o_addr_2_reg(addr_2), .o_stall_up(stall_up),
    .o_rd_valid(rd_valid), .o_rd_opcode(rd_opcode), .o_rd_dest(rd_dest),
    .o_rd_op1(rd_op1), .o_rd_op2(rd_op2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      m_e = q.pop_front();
      total++;
      if (rd_valid !== m_e.v || (m_e.full && (rd_opcode !== m_e.opc || rd_dest !== m_e.dst ||
          rd_op1 !== m_e.op1 || rd_op2 !== m_e.op2))) begin
        bad++;
        $display("FAIL %s got v=%0b opc=%h dst=%0d op1=%h op2=%h want v=%0b opc=%h dst=%0d op1=%h op2=%h",
                 m_e.nm, rd_valid, rd_opcode, rd_dest, rd_op1, rd_op2,
                 m_e.v, m_e.opc, m_e.dst, m_e.op1, m_e.op2);
      end
    end
  end
  task automatic expect_rd(input string nm, input logic v, input logic [6:0] opc,
                           input logic [2:0] dst, input logic [31:0] a, input logic [31:0] b,
                           input bit full);
    exp_t e;
    e.due = cyc + 1; e.nm = nm; e.v = v; e.opc = opc; e.dst = dst;
    e.op1 = a; e.op2 = b; e.full = full;
    q.push_back(e);
  endtask
  task automatic chk_comb(input string nm, input logic want_stall);
    #1;
    total++;
    if (stall_up !== want_stall || addr_1 !== id_src1 || addr_2 !== id_src2) begin
      bad++;
      $display("FAIL %s got stall=%0b a1=%0d a2=%0d want stall=%0b a1=%0d a2=%0d",
               nm, stall_up, addr_1, addr_2, want_stall, id_src1, id_src2);
    end
  endtask
  task automatic chk_zero(input string nm);
    total++;
    if ({rd_valid, rd_opcode, rd_dest, rd_op1, rd_op2} !== '0) begin
      bad++;
      $display("FAIL %s got v=%0b opc=%h dst=%0d op1=%h op2=%h want all zero",
               nm, rd_valid, rd_opcode, rd_dest, rd_op1, rd_op2);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    id_valid = 0; id_use1 = 0; id_use2 = 0; flush = 0; ex_hold = 0; ex_valid = 0;
    ex_is_load = 0; wb_write_en = 0; id_opcode = 0; id_dest = 0; id_src1 = 0; id_src2 = 0;
    ex_dest = 0; wb_dest = 0; ex_result = 0; wb_result = 0; data_1 = 0; data_2 = 0;
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    reset_n = 0;
    idle();
    #3 chk_zero("reset_init");
    tick(); tick();
    reset_n = 1;
    // EX forwarding
    id_valid = 1; id_opcode = 7'h13; id_dest = 1; id_src1 = 3; id_use1 = 1; id_src2 = 4; id_use2 = 1;
    ex_valid = 1; ex_dest = 3; ex_result = 32'hAAAA5555; data_1 = 32'h1; data_2 = 32'h22;
    chk_comb("ex_fwd_comb", 0);
    expect_rd("ex_fwd", 1, 7'h13, 1, 32'hAAAA5555, 32'h22, 1); tick();
    wb_write_en = 1; wb_dest = 3; wb_result = 32'h7;
    chk_comb("ex_over_wb_comb", 0);
    expect_rd("ex_over_wb", 1, 7'h13, 1, 32'hAAAA5555, 32'h22, 1); tick();
    // WB forwarding
    ex_valid = 0; wb_dest = 5; wb_result = 32'h42; id_src1 = 1; data_1 = 32'h11;
    id_src2 = 5; data_2 = 32'h9; id_opcode = 7'h33; id_dest = 6;
    chk_comb("wb_fwd_comb", 0);
    expect_rd("wb_fwd", 1, 7'h33, 6, 32'h11, 32'h42, 1); tick();
    // Load-use bubble, then operand arrives via writeback
    wb_write_en = 0; ex_valid = 1; ex_is_load = 1; ex_dest = 2; ex_result = 32'hBAD0BAD0;
    id_src1 = 2; id_use1 = 1; id_src2 = 0; id_use2 = 0; id_opcode = 7'h23; id_dest = 7;
    data_1 = 32'h5; data_2 = 32'h66;
    chk_comb("luh_stall", 1);
    expect_rd("luh_bubble", 0, 0, 0, 0, 0, 0); tick();
    ex_valid = 0; ex_is_load = 0; wb_write_en = 1; wb_dest = 2; wb_result = 32'hDEAD;
    chk_comb("luh_release", 0);
    expect_rd("luh_wb_op", 1, 7'h23, 7, 32'hDEAD, 32'h66, 1); tick();
    // Unused source never stalls; loads never forward from execute
    wb_write_en = 0; ex_valid = 1; ex_is_load = 1; ex_dest = 2; id_src1 = 2; id_use1 = 0;
    id_src2 = 3; id_use2 = 1; data_1 = 32'h55; data_2 = 32'h77; id_opcode = 7'h01; id_dest = 4;
    chk_comb("unused_src_comb", 0);
    expect_rd("unused_src", 1, 7'h01, 4, 32'h55, 32'h77, 1); tick();
    // Both sources hit the same load: one bubble
    ex_dest = 4; id_src1 = 4; id_src2 = 4; id_use1 = 1; id_use2 = 1; id_opcode = 7'h05; id_dest = 3;
    chk_comb("dual_luh_stall", 1);
    expect_rd("dual_luh_bubble", 0, 0, 0, 0, 0, 0); tick();
    ex_valid = 0; ex_is_load = 0; wb_write_en = 1; wb_dest = 4; wb_result = 32'h99;
    chk_comb("dual_luh_release", 0);
    expect_rd("dual_luh_op", 1, 7'h05, 3, 32'h99, 32'h99, 1); tick();
    // Invalid decode slot does not stall on a load match
    wb_write_en = 0; ex_valid = 1; ex_is_load = 1; ex_dest = 4; id_valid = 0;
    chk_comb("invalid_no_stall", 0);
    expect_rd("invalid_capture", 0, 0, 0, 0, 0, 0); tick();
    // Hold for three cycles
    idle();
    id_valid = 1; id_opcode = 7'h11; id_dest = 2; id_src1 = 1; id_src2 = 2; id_use1 = 1; id_use2 = 1;
    data_1 = 32'hA; data_2 = 32'hB;
    chk_comb("pre_hold_comb", 0);
    expect_rd("pre_hold", 1, 7'h11, 2, 32'hA, 32'hB, 1); tick();
    ex_hold = 1; id_opcode = 7'h22; id_dest = 5; data_1 = 32'hF0; data_2 = 32'hF1;
    for (int i = 0; i < 3; i++) begin
      chk_comb("hold_stall", 1);
      expect_rd("hold", 1, 7'h11, 2, 32'hA, 32'hB, 1); tick();
    end
    // Hold with pending load-use: hold wins, bubble follows
    ex_valid = 1; ex_is_load = 1; ex_dest = 1;
    chk_comb("hold_luh_stall", 1);
    expect_rd("hold_luh", 1, 7'h11, 2, 32'hA, 32'hB, 1); tick();
    ex_hold = 0;
    chk_comb("after_hold_luh_stall", 1);
    expect_rd("after_hold_bubble", 0, 0, 0, 0, 0, 0); tick();
    // Flush beats hold and load-use
    ex_hold = 1; flush = 1; ex_valid = 0; ex_is_load = 0;
    chk_comb("flush_hold_stall", 1);
    expect_rd("flush_hold", 0, 0, 0, 0, 0, 0); tick();
    ex_hold = 0; ex_valid = 1; ex_is_load = 1; ex_dest = 1;
    chk_comb("flush_luh_stall", 0);
    expect_rd("flush_luh", 0, 0, 0, 0, 0, 0); tick();
    // Async reset mid-run
    idle();
    id_valid = 1; id_opcode = 7'h7F; id_dest = 3; id_src1 = 6; id_src2 = 7;
    data_1 = 32'h1234; data_2 = 32'h5678;
    chk_comb("pre_reset_comb", 0);
    expect_rd("pre_reset", 1, 7'h7F, 3, 32'h1234, 32'h5678, 1); tick();
    @(negedge clk); #1;
    reset_n = 0;
    #1 chk_zero("async_reset");
    tick();
    chk_zero("reset_held");
    reset_n = 1;
    id_opcode = 7'h0C; data_1 = 32'h4321;
    expect_rd("post_reset", 1, 7'h0C, 3, 32'h4321, 32'h5678, 1); tick();
    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/read_stage.md
# read_stage

Register-read pipeline stage of the pipelined RISC core. It sits between decode and execute. It drives the register file read addresses from the decoded source fields and resolves data hazards by forwarding from the execute and writeback stages. It inserts a one-cycle bubble on a load-use hazard and latches the resolved operands into the read/execute pipeline register.

## Interface
- A_SIZE, 10, address width; passed through to the execute-stage memory-address path.
- D_SIZE, 32, data width of registers, operands and results.
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_opcode  in  7  decoded opcode; passed through unchanged.
- id_dest  in  3  destination register index.
- id_src1, id_src2  in  3 each  source register indices.
- id_use1, id_use2  in  1 each  the instruction actually reads src1 / src2.
- flush  in  1  branch taken in execute; kill the instruction in this stage.
- ex_hold  in  1  execute cannot accept a new instruction this cycle.
- ex_valid, ex_is_load  in  1 each  execute-stage instruction is valid / is a load.
- ex_dest  in  3  execute-stage destination register.
- ex_result  in  D_SIZE  execute ALU result; valid in the same cycle.
- wb_write_en  in  1  writeback is writing the register file this cycle.
- wb_dest  in  3  writeback destination register.
- wb_result  in  D_SIZE  writeback data.
- data_1_reg, data_2_reg  in  D_SIZE each  register file read data (combinational).
- addr_1_reg, addr_2_reg  out  3 each  equal id_src1 / id_src2; combinational.
- stall_up  out  1  decode must hold its instruction; combinational.
- rd_valid  out  1  pipeline register: instruction valid for execute.
- rd_opcode  out  7  pipeline register: opcode.
- rd_dest  out  3  pipeline register: destination index.
- rd_op1, rd_op2  out  D_SIZE each  pipeline register: resolved operands.

## Operation
- Operand select, evaluated independently for op1 and op2, in priority order:
  - (a) ex_valid && !ex_is_load && ex_dest==src selects ex_result.
  - (b) wb_write_en && wb_dest==src selects wb_result.
  - (c) otherwise, data_N_reg.
  - Writeback forwarding is mandatory because the register file commits on the clock edge, so a same-cycle read returns the old value.
- Load-use hazard:
  - luh = id_valid && ex_valid && ex_is_load && ((id_use1 && ex_dest==id_src1) || (id_use2 && ex_dest==id_src2)).
  - An unused source never causes a hazard.
- stall_up = ex_hold || (luh && !flush).
- Pipeline register update on each rising edge, highest priority first:
  - reset low: rd_valid, rd_opcode, rd_dest, rd_op1 and rd_op2 all become 0 asynchronously.
  - flush: rd_valid becomes 0. The other pipeline fields are don't-care. Flush overrides ex_hold and luh.
  - ex_hold: all rd_* fields hold their current values.
  - luh: bubble; rd_valid becomes 0 and decode holds its instruction.
  - otherwise: capture id_valid, id_opcode, id_dest and the selected operands.
- After one bubble the load has reached writeback, so rule (b) supplies its data and luh clears without extra state.
- Operands are unsigned bit vectors; no width conversion is performed.

## Timing
- Read-to-execute latency is 1 cycle, or 2 cycles with a load-use bubble.
- addr_*_reg and stall_up are combinational from the current-cycle inputs.
- All rd_* outputs are registered. Reset value of every output register is 0.
- Reset deasserted mid-pipeline: the first capture happens on the first rising edge with reset high.
- Simultaneous events:
  - ex and wb both matching a source: ex wins.
  - Both sources matching the same load: a single one-cycle bubble.
  - ex_hold together with luh: hold, no bubble; luh is re-evaluated after the hold clears.

## Test plan
- Reset: drive reset=0 mid-run with rd_op1=0x1234 -> all rd_* outputs go to 0 immediately, before any clock edge.
- EX forwarding: ex_dest=3, ex_result=0xAAAA5555, id_src1=3, id_use1=1, register file r3=0x1 -> rd_op1=0xAAAA5555 on the next edge. Then add wb_dest=3, wb_result=0x7 -> ex still wins.
- WB forwarding: wb_write_en=1, wb_dest=5, wb_result=0x42, id_src2=5, data_2_reg=0x9 -> rd_op2=0x42.
- Load-use: load to r2 in execute, next instruction with id_src1=2, id_use1=1 -> stall_up=1 for exactly 1 cycle and rd_valid=0 for 1 cycle. The following cycle rd_op1 equals the loaded value taken via wb.
- Unused source: same as load-use but id_use1=0 -> no stall; the instruction is captured immediately.
- Flush vs hold: ex_hold=1 and flush=1 together -> rd_valid=0 on the next edge. ex_hold=1 alone for 3 cycles -> rd_* unchanged and stall_up=1 throughout.
